// File: rtl/seq_detect_pkg.sv
// Shared defaults and width helper for the parameterised serial pattern detector.
package seq_detect_pkg;

  localparam int PAT_MAX_DEF = 8;
  localparam int CNT_W_DEF   = 16;

  // Bits needed to hold a pattern length in the range 0..pat_max.
  function automatic int len_width(input int pat_max);
    return $clog2(pat_max + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter. A clear concurrent with an increment yields one,
// so an event landing on the clear edge is never lost.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count register: clear has priority, increments stop at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= inc ? CNT_W'(1'b1) : {CNT_W{1'b0}};
    end else if (inc && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with run-time pattern/length/overlap configuration
// held in shadow registers. A match is judged on the post-shift history so the
// pulse is registered on the edge that accepts the completing bit.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter  int PAT_MAX = PAT_MAX_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int LEN_W   = len_width(PAT_MAX)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               data_valid,
  input  logic               data_in,
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] PAT_MAX_L = LEN_W'(PAT_MAX);
  localparam logic [LEN_W-1:0] LEN_MIN_L = LEN_W'(2);

  logic [PAT_MAX-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               overlap_r;
  logic               cfg_err_r;
  logic [PAT_MAX-1:0] hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic               detected_r;

  logic [PAT_MAX-1:0] hist_nxt_s;
  logic [LEN_W-1:0]   fill_inc_s;
  logic [PAT_MAX-1:0] mask_s;
  logic               match_s;

  // Shadow configuration; the error flag is derived once at load time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_r     <= {PAT_MAX{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      overlap_r <= 1'b1;
      cfg_err_r <= 1'b1;
    end else if (cfg_load) begin
      pat_r     <= cfg_pattern;
      len_r     <= cfg_len;
      overlap_r <= cfg_overlap;
      cfg_err_r <= (cfg_len < LEN_MIN_L) || (cfg_len > PAT_MAX_L);
    end else begin
      pat_r     <= pat_r;
      len_r     <= len_r;
      overlap_r <= overlap_r;
      cfg_err_r <= cfg_err_r;
    end
  end

  // Next-state history/fill and match decision on the post-shift values.
  always_comb begin
    hist_nxt_s = {hist_r[PAT_MAX-2:0], data_in};
    fill_inc_s = (fill_r == PAT_MAX_L) ? fill_r : (fill_r + LEN_W'(1'b1));
    mask_s     = {PAT_MAX{1'b0}};
    match_s    = 1'b0;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask_s[i] = (LEN_W'(i) < len_r);
    end
    if (data_valid && !cfg_load && !cfg_err_r) begin
      match_s = (((hist_nxt_s ^ pat_r) & mask_s) == {PAT_MAX{1'b0}}) &&
                (fill_inc_s >= len_r);
    end else begin
      match_s = 1'b0;
    end
  end

  // Stream state: a load flushes progress and discards any concurrent bit;
  // non-overlap mode restarts the fill count on a match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r     <= {PAT_MAX{1'b0}};
      fill_r     <= {LEN_W{1'b0}};
      detected_r <= 1'b0;
    end else if (cfg_load) begin
      hist_r     <= {PAT_MAX{1'b0}};
      fill_r     <= {LEN_W{1'b0}};
      detected_r <= 1'b0;
    end else if (data_valid) begin
      hist_r     <= hist_nxt_s;
      fill_r     <= (match_s && !overlap_r) ? {LEN_W{1'b0}} : fill_inc_s;
      detected_r <= match_s;
    end else begin
      hist_r     <= hist_r;
      fill_r     <= fill_r;
      detected_r <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (match_s),
    .count (match_count)
  );

  assign detected = detected_r;
  assign cfg_err  = cfg_err_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: two detectors share one stimulus stream, one with the
// default counter width and one with a 2-bit counter for saturation.
module tb_seq_detect_param;

  localparam int PAT_MAX = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_load = 1'b0;
  logic [PAT_MAX-1:0] cfg_pattern = 8'h00;
  logic [LEN_W-1:0]   cfg_len = 4'd0;
  logic               cfg_overlap = 1'b0;
  logic               data_valid = 1'b0;
  logic               data_in = 1'b0;
  logic               cnt_clr = 1'b0;

  logic        det_a, err_a, det_b, err_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_MAX(PAT_MAX), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .data_valid(data_valid),
    .data_in(data_in), .cnt_clr(cnt_clr), .detected(det_a),
    .match_count(cnt_a), .cfg_err(err_a)
  );

  seq_detect_param #(.PAT_MAX(PAT_MAX), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .data_valid(data_valid),
    .data_in(data_in), .cnt_clr(cnt_clr), .detected(det_b),
    .match_count(cnt_b), .cfg_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic counts(input string tag, input logic [15:0] ea, input logic [1:0] eb);
    chk({tag, "_cnt_a"}, {16'd0, cnt_a}, {16'd0, ea});
    chk({tag, "_cnt_b"}, {30'd0, cnt_b}, {30'd0, eb});
  endtask

  // One cycle of stream input, then check the registered pulse.
  task automatic sb(input logic v, input logic d, input logic c, input logic exp_det,
                    input string tag);
    @(negedge clk);
    data_valid = v;
    data_in    = d;
    cnt_clr    = c;
    @(posedge clk);
    #1;
    chk({tag, "_det_a"}, {31'd0, det_a}, {31'd0, exp_det});
    chk({tag, "_det_b"}, {31'd0, det_b}, {31'd0, exp_det});
    cnt_clr = 1'b0;
  endtask

  // Send n valid bits, bits[n-1] first, with matching expected pulses.
  task automatic stream(input int n, input logic [31:0] bits, input logic [31:0] exp,
                        input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      sb(1'b1, bits[i], 1'b0, exp[i], $sformatf("%s_b%0d", tag, n - i));
    end
  endtask

  // Load config with a concurrent valid bit that must be discarded.
  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                      input logic exp_err, input string tag);
    @(negedge clk);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    data_valid  = 1'b1;
    data_in     = 1'b1;
    cnt_clr     = 1'b0;
    @(posedge clk);
    #1;
    cfg_load   = 1'b0;
    data_valid = 1'b0;
    chk({tag, "_err"}, {31'd0, err_a}, {31'd0, exp_err});
    chk({tag, "_ldet"}, {31'd0, det_a}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_det", {31'd0, det_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd1);
    counts("rst", 16'd0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Overlap: 1011 in 1011011 -> pulses after bits 4 and 7
    load(8'h0B, 4'd4, 1'b1, 1'b0, "ov_load");
    stream(7, 32'b1011011, 32'b0001001, "ov");
    counts("ov", 16'd2, 2'd2);

    // Non-overlap: only the first match
    sb(1'b0, 1'b0, 1'b1, 1'b0, "clr0");
    counts("clr0", 16'd0, 2'd0);
    load(8'h0B, 4'd4, 1'b0, 1'b0, "nov_load");
    stream(7, 32'b1011011, 32'b0001000, "nov");
    counts("nov", 16'd1, 2'd1);

    // Valid gap, with unloaded cfg changes during the gap
    load(8'h0B, 4'd4, 1'b1, 1'b0, "gap_load");
    stream(2, 32'b10, 32'b00, "gap_pre");
    cfg_pattern = 8'h00;
    cfg_len     = 4'd2;
    cfg_overlap = 1'b0;
    for (int i = 0; i < 3; i++) sb(1'b0, 1'b1, 1'b0, 1'b0, "gap_idle");
    stream(2, 32'b11, 32'b01, "gap_post");
    counts("gap", 16'd2, 2'd2);

    // Illegal lengths
    load(8'h01, 4'd1, 1'b1, 1'b1, "len1");
    load(8'hFF, 4'd9, 1'b1, 1'b1, "len9");
    stream(10, 32'b1111111111, 32'b0, "len9");
    counts("len9", 16'd2, 2'd2);

    // Mid-stream reset discards progress
    load(8'h0B, 4'd4, 1'b1, 1'b0, "rs_load");
    stream(3, 32'b101, 32'b000, "rs_pre");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs_det", {31'd0, det_a}, 32'd0);
    chk("rs_err", {31'd0, err_a}, 32'd1);
    counts("rs", 16'd0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load(8'h0B, 4'd4, 1'b1, 1'b0, "rs_reload");
    stream(1, 32'b1, 32'b0, "rs_one");
    stream(3, 32'b011, 32'b001, "rs_rest");
    counts("rs_rest", 16'd1, 2'd1);

    // Saturation of the 2-bit counter
    stream(12, 32'b011011011011, 32'b001001001001, "sat");
    counts("sat", 16'd5, 2'd3);
    stream(2, 32'b01, 32'b00, "clrm_pre");
    sb(1'b1, 1'b1, 1'b1, 1'b1, "clrm");
    counts("clrm", 16'd1, 2'd1);
    sb(1'b0, 1'b0, 1'b1, 1'b0, "clr1");
    counts("clr1", 16'd0, 2'd0);

    // Full-length pattern
    load(8'hFF, 4'd8, 1'b1, 1'b0, "full_load");
    stream(10, 32'b1111111111, 32'b0000000111, "full");
    counts("full", 16'd3, 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_MAX, default 8, the maximum pattern length in bits (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default 16, the width of the match counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cfg_load, input, 1 bit: latches cfg_pattern, cfg_len and cfg_overlap into shadow registers.
REQ-006 SHALL have port cfg_pattern, input, PAT_MAX bits: target pattern; bit [len-1] is the first bit received, bit [0] the last.
REQ-007 SHALL have port cfg_len, input, clog2(PAT_MAX+1) bits: active pattern length.
REQ-008 SHALL have port cfg_overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port data_valid, input, 1 bit: qualifies data_in for the current cycle.
REQ-010 SHALL have port data_in, input, 1 bit: serial stream bit.
REQ-011 SHALL have port cnt_clr, input, 1 bit: synchronous clear of match_count.
REQ-012 SHALL have port detected, output, 1 bit: registered one-cycle match pulse.
REQ-013 SHALL have port match_count, output, CNT_W bits: saturating count of matches.
REQ-014 SHALL have port cfg_err, output, 1 bit: high while the latched cfg_len is 0, 1, or greater than PAT_MAX.

Function
REQ-015 SHALL keep a PAT_MAX-bit history register; on each edge with data_valid=1 it SHALL update as hist <= {hist[PAT_MAX-2:0], data_in}.
REQ-016 SHALL keep a fill counter of accepted bits that increments per accepted bit and saturates at PAT_MAX.
REQ-017 SHALL evaluate a match on the next-state values: next_hist[len-1:0] == pattern[len-1:0] and next_fill >= len.
REQ-018 SHALL set detected on the edge that accepts the completing bit (visible the following cycle), for exactly one cycle; otherwise detected = 0.
REQ-019 In overlap mode, the fill counter SHALL continue normally after a match (1011 on stream 1011011 yields two matches).
REQ-020 In non-overlap mode, the fill counter SHALL load 0 on a match edge, so no bit is shared between matches.
REQ-021 With data_valid=0, history, fill and the counter SHALL hold, and detected SHALL be 0.
REQ-022 On a cfg_load edge, the shadow config SHALL update, history and fill SHALL clear to 0, and any concurrent data_valid bit SHALL be discarded (load wins).
REQ-023 While cfg_err=1, detected SHALL stay 0 and match_count SHALL hold.
REQ-024 match_count SHALL increment on each detected edge and saturate at all-ones (no wrap).
REQ-025 On simultaneous cnt_clr and a match, match_count SHALL become 1; cnt_clr alone SHALL give 0.
REQ-026 Config changes on the cfg_* ports without cfg_load SHALL have no effect.

Reset
REQ-027 While rst_n=0 (asynchronous), the block SHALL hold: hist=0, fill=0, detected=0, match_count=0, shadow pattern=0, shadow len=0, shadow overlap=1, cfg_err=1.
REQ-028 Reset assertion mid-stream SHALL discard all partial match progress; after rst_n rises, the first match SHALL require a full cfg_load and len fresh bits.

Structure
REQ-029 A shared package seq_detect_pkg SHALL hold PAT_MAX/CNT_W defaults and the length-width function clog2-based constant.
REQ-030 One sub-module, sat_counter (CNT_W parameter, clr/inc, saturating), SHALL implement match_count; everything else stays in seq_detect_param.

Verification
REQ-031 Overlap test: load pattern=1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 with data_valid=1 -> detected after the 4th and 7th bits; match_count=2.
REQ-032 Non-overlap test: same load with overlap=0 and the same stream -> detected after the 4th bit only; match_count=1.
REQ-033 Valid-gap test: stream 1,0,(valid=0 for 3 cycles),1,1 -> detected exactly one cycle after the last accepted bit; stays 0 during the gap.
REQ-034 Config/reset test: cfg_len=9 with PAT_MAX=8 -> cfg_err=1 and no detection. Assert rst_n=0 after bits 1,0,1; after release, reload and send 1 -> no detection.
REQ-035 Saturation test: CNT_W=2 with 5 matches -> match_count=3. Then cnt_clr concurrent with a match -> match_count=1.
REQ-036 Full-length test: PAT_MAX=8, len=8, pattern 11111111, overlap=1, ten 1s -> detected after bits 8, 9 and 10.
